tcp_session_tracker: RTL and testbench

TCP_SESSION_TRACKER -- requirements
Module: tcp_session_tracker

---
 rtl/tcp_pkg.sv | 36 +++
 rtl/tcp_session_tracker_if.sv | 32 +++
 rtl/tcp_conn_timer.sv | 34 +++
 rtl/tcp_session_tracker.sv | 107 ++++++++++
 tb/tb_tcp_session_tracker.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/tcp_pkg.sv
// tcp_pkg: shared definitions for the TCP session tracker.
//   conn_state_e : per-connection FSM encoding (LISTEN=0 .. CLOSING=3)
//   FLAG_*       : bit positions inside the 8-bit flag field
//   flags_t      : decoded flag bits
//   decode_flags : low nibble of the flag field -> flags_t
package tcp_pkg;

  typedef enum logic [1:0] {
    LISTEN      = 2'd0,
    SYN_RCVD    = 2'd1,
    ESTABLISHED = 2'd2,
    CLOSING     = 2'd3
  } conn_state_e;

  localparam int FLAG_SYN = 0;
  localparam int FLAG_ACK = 1;
  localparam int FLAG_FIN = 2;
  localparam int FLAG_RST = 3;

  typedef struct packed {
    logic rst;
    logic fin;
    logic ack;
    logic syn;
  } flags_t;

  function automatic flags_t decode_flags(input logic [3:0] f);
    flags_t r;
    r.syn = f[FLAG_SYN];
    r.ack = f[FLAG_ACK];
    r.fin = f[FLAG_FIN];
    r.rst = f[FLAG_RST];
    return r;
  endfunction

endpackage

// File: rtl/tcp_session_tracker_if.sv
// tcp_session_tracker_if: packet-in / packet-out handshake bundle.
//   PACKET_READY, PAYLOAD_DATA, CONN_ID : inbound packet (valid, word, conn)
//   IN_READY                            : tracker can take the inbound packet
//   PACKET_READY_OUT, PAYLOAD_DATA_OUT,
//   CONN_ID_OUT                         : forwarded packet
//   OUT_READY                           : downstream takes the forwarded packet
// Modports: master = traffic source/sink, slave = tracker.
interface tcp_session_tracker_if #(
  parameter int NUM_CONN = 4,
  parameter int DATA_W   = 32
);
  localparam int ID_W = $clog2(NUM_CONN);

  logic              PACKET_READY;
  logic [DATA_W-1:0] PAYLOAD_DATA;
  logic [ID_W-1:0]   CONN_ID;
  logic              IN_READY;
  logic              PACKET_READY_OUT;
  logic [DATA_W-1:0] PAYLOAD_DATA_OUT;
  logic [ID_W-1:0]   CONN_ID_OUT;
  logic              OUT_READY;

  modport master (
    output PACKET_READY, PAYLOAD_DATA, CONN_ID, OUT_READY,
    input  IN_READY, PACKET_READY_OUT, PAYLOAD_DATA_OUT, CONN_ID_OUT
  );

  modport slave (
    input  PACKET_READY, PAYLOAD_DATA, CONN_ID, OUT_READY,
    output IN_READY, PACKET_READY_OUT, PAYLOAD_DATA_OUT, CONN_ID_OUT
  );
endinterface

// File: rtl/tcp_conn_timer.sv
// tcp_conn_timer: idle counter for one connection in SYN_RCVD.
//   clk_i, rst_i : clock, synchronous active-high reset
//   run_i        : connection is in SYN_RCVD this cycle
//   timeout_o    : counter has reached TIMEOUT_CYCLES-1 while running
// The counter is held at zero whenever run_i is low, so it is already clear
// on the first cycle of SYN_RCVD.
module tcp_conn_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic timeout_o
);
  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST: if a dropped packet outvotes the timeout, the pulse
  // simply repeats next cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i)             cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = run_i && (cnt_q == LAST);
endmodule

// File: rtl/tcp_session_tracker.sv
// tcp_session_tracker: per-connection TCP handshake tracker and data filter.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : tcp_session_tracker_if.slave (packet in / packet out)
//   EST_MASK   : bit i high while connection i is ESTABLISHED
//   DROP_COUNT : saturating count of accepted-but-not-forwarded packets,
//                present only when TCP_TRACKER_STATS_EN is defined
// Flags live in PAYLOAD_DATA[DATA_W-1:DATA_W-8]; RST beats all other flags.
// Only ESTABLISHED forwards; output is a single register stage.
module tcp_session_tracker
  import tcp_pkg::*;
#(
  parameter int NUM_CONN       = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  tcp_session_tracker_if.slave bus,
  output logic [NUM_CONN-1:0] EST_MASK
`ifdef TCP_TRACKER_STATS_EN
  ,
  output logic [15:0]         DROP_COUNT
`endif
);
  localparam int ID_W = $clog2(NUM_CONN);

  conn_state_e [NUM_CONN-1:0] state_q, state_d;
  logic        [NUM_CONN-1:0] tmo;
  logic                       acc, fwd;
  flags_t                     flg;

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   id_q;

  assign bus.IN_READY = !vld_q || bus.OUT_READY;
  assign acc = bus.PACKET_READY && bus.IN_READY;
  assign flg = decode_flags(bus.PAYLOAD_DATA[DATA_W-8 +: 4]);

  for (genvar g = 0; g < NUM_CONN; g++) begin : g_conn
    tcp_conn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .run_i    (state_q[g] == SYN_RCVD),
      .timeout_o(tmo[g])
    );
    assign EST_MASK[g] = (state_q[g] == ESTABLISHED);
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= {NUM_CONN{LISTEN}};
    else       state_q <= state_d;
  end

  // Timeouts are applied first so an accepted packet on the same connection
  // overrides them (every packet branch writes the target state explicitly).
  always_comb begin
    state_d = state_q;
    fwd     = 1'b0;
    for (int i = 0; i < NUM_CONN; i++)
      if (tmo[i]) state_d[i] = LISTEN;
    if (acc) begin
      if (flg.rst) begin
        state_d[bus.CONN_ID] = LISTEN;
      end else begin
        unique case (state_q[bus.CONN_ID])
          LISTEN:      state_d[bus.CONN_ID] = (flg.syn && !flg.ack) ? SYN_RCVD : LISTEN;
          SYN_RCVD:    state_d[bus.CONN_ID] = (flg.syn && flg.ack) ? ESTABLISHED : SYN_RCVD;
          ESTABLISHED: begin
            fwd                  = 1'b1;
            state_d[bus.CONN_ID] = flg.fin ? CLOSING : ESTABLISHED;
          end
          CLOSING:     state_d[bus.CONN_ID] = flg.ack ? LISTEN : CLOSING;
          default:     state_d[bus.CONN_ID] = LISTEN;
        endcase
      end
    end
  end

  // A new forward may load in the same cycle the old one drains.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
    end else if (fwd) begin
      vld_q  <= 1'b1;
      data_q <= bus.PAYLOAD_DATA;
      id_q   <= bus.CONN_ID;
    end else if (bus.OUT_READY) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.PACKET_READY_OUT = vld_q;
  assign bus.PAYLOAD_DATA_OUT = data_q;
  assign bus.CONN_ID_OUT      = id_q;

`ifdef TCP_TRACKER_STATS_EN
  logic [15:0] drop_q;
  always_ff @(posedge CLK) begin
    if (RESET)                           drop_q <= '0;
    else if (acc && !fwd && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign DROP_COUNT = drop_q;
`endif
endmodule

// File: tb/tb_tcp_session_tracker.sv
module tb_tcp_session_tracker;
  logic CLK = 1'b0;
  logic RESET;
  logic [3:0] est_mask;
`ifdef TCP_TRACKER_STATS_EN
  logic [15:0] drop_count;
`endif
  int n_chk = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  tcp_session_tracker_if #(.NUM_CONN(4), .DATA_W(32)) bus ();

  tcp_session_tracker #(.NUM_CONN(4), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus.slave),
    .EST_MASK  (est_mask)
`ifdef TCP_TRACKER_STATS_EN
    ,
    .DROP_COUNT(drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One packet held for one posedge; returns at the following negedge.
  task automatic send(input logic [1:0] id, input logic [31:0] d);
    @(negedge CLK);
    bus.PACKET_READY = 1'b1;
    bus.CONN_ID      = id;
    bus.PAYLOAD_DATA = d;
    @(negedge CLK);
    bus.PACKET_READY = 1'b0;
  endtask

  task automatic drops(input string tag, input int exp);
`ifdef TCP_TRACKER_STATS_EN
    chk(tag, {16'd0, drop_count}, exp);
`endif
  endtask

  initial begin
    RESET = 1'b1;
    bus.PACKET_READY = 1'b0;
    bus.PAYLOAD_DATA = '0;
    bus.CONN_ID      = '0;
    bus.OUT_READY    = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_vld",  bus.PACKET_READY_OUT, 0);
    chk("rst_data", bus.PAYLOAD_DATA_OUT, 0);
    chk("rst_id",   bus.CONN_ID_OUT, 0);
    chk("rst_mask", est_mask, 0);
    drops("rst_drop", 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_inrdy", bus.IN_READY, 1);

    // conn 2 handshake then data
    send(2, 32'h0100_0000);
    chk("c2_syn_mask", est_mask, 0);
    chk("c2_syn_vld",  bus.PACKET_READY_OUT, 0);
    send(2, 32'h0300_0000);
    chk("c2_est_mask", est_mask, 4'h4);
    chk("c2_sa_vld",   bus.PACKET_READY_OUT, 0);
    send(2, 32'h00AB_CDEF);
    chk("c2_fwd_vld",  bus.PACKET_READY_OUT, 1);
    chk("c2_fwd_data", bus.PAYLOAD_DATA_OUT, 32'h00AB_CDEF);
    chk("c2_fwd_id",   bus.CONN_ID_OUT, 2);
    @(negedge CLK);
    chk("c2_clr_vld",  bus.PACKET_READY_OUT, 0);
    drops("c2_drop", 2);

    // conn 1: SYN-ACK on the last SYN_RCVD cycle beats the timeout
    send(1, 32'h0100_0000);
    repeat (14) @(negedge CLK);
    send(1, 32'h0300_0000);
    chk("c1_edge_mask", est_mask, 4'h6);
    send(1, 32'h0800_0000);
    chk("c1_rst_mask", est_mask, 4'h4);
    // conn 1: one cycle later the timeout has already won
    send(1, 32'h0100_0000);
    repeat (15) @(negedge CLK);
    send(1, 32'h0300_0000);
    chk("c1_tmo_mask", est_mask, 4'h4);
    chk("c1_tmo_vld",  bus.PACKET_READY_OUT, 0);
    drops("c1_drop", 7);

    // conn 0: backpressure
    send(0, 32'h0100_0000);
    send(0, 32'h0300_0000);
    chk("c0_est_mask", est_mask, 4'h5);
    @(negedge CLK);
    bus.OUT_READY = 1'b0;
    send(0, 32'h0000_1111);
    chk("c0_stall_vld",  bus.PACKET_READY_OUT, 1);
    chk("c0_stall_inrdy", bus.IN_READY, 0);
    bus.PACKET_READY = 1'b1;
    bus.CONN_ID      = 2'd0;
    bus.PAYLOAD_DATA = 32'h0000_2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("c0_hold_data",  bus.PAYLOAD_DATA_OUT, 32'h0000_1111);
      chk("c0_hold_vld",   bus.PACKET_READY_OUT, 1);
      chk("c0_hold_inrdy", bus.IN_READY, 0);
    end
    bus.OUT_READY = 1'b1;
    #1 chk("c0_rel_inrdy", bus.IN_READY, 1);
    @(negedge CLK);
    bus.PACKET_READY = 1'b0;
    chk("c0_next_vld",  bus.PACKET_READY_OUT, 1);
    chk("c0_next_data", bus.PAYLOAD_DATA_OUT, 32'h0000_2222);
    @(negedge CLK);
    chk("c0_drain_vld", bus.PACKET_READY_OUT, 0);
    drops("c0_drop", 9);

    // conn 3: all flags set -> RST wins
    send(3, 32'h0100_0000);
    send(3, 32'h0300_0000);
    chk("c3_est_mask", est_mask, 4'hD);
    drops("c3_drop_pre", 11);
    send(3, 32'h0F00_0000);
    chk("c3_rst_vld",  bus.PACKET_READY_OUT, 0);
    chk("c3_rst_mask", est_mask, 4'h5);
    drops("c3_drop_post", 12);

    // conn 0: FIN forwarded, ACK closes
    send(0, 32'h0400_0001);
    chk("c0_fin_vld",  bus.PACKET_READY_OUT, 1);
    chk("c0_fin_data", bus.PAYLOAD_DATA_OUT, 32'h0400_0001);
    chk("c0_fin_mask", est_mask, 4'h4);
    send(0, 32'h0200_0000);
    chk("c0_ack_vld",  bus.PACKET_READY_OUT, 0);
    chk("c0_ack_mask", est_mask, 4'h4);
    // a fresh handshake only completes if conn 0 is back in LISTEN
    send(0, 32'h0100_0000);
    send(0, 32'h0300_0000);
    chk("c0_relisten_mask", est_mask, 4'h5);
    drops("c0_drop2", 15);

    // reset with output stalled
    @(negedge CLK);
    bus.OUT_READY = 1'b0;
    send(2, 32'h0000_BEEF);
    chk("rs_stall_vld", bus.PACKET_READY_OUT, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rs_mask", est_mask, 0);
    chk("rs_vld",  bus.PACKET_READY_OUT, 0);
    chk("rs_data", bus.PAYLOAD_DATA_OUT, 0);
    drops("rs_drop", 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rs_inrdy", bus.IN_READY, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
